// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage stall/flush, drained PC redirect,
// qualified timer-interrupt strobe and a sticky fetch-drain watchdog.
module pipe_ctrl #(
  parameter int PC_W       = 64,
  parameter int WAIT_CNT_W = 8,
  parameter int WAIT_MAX   = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_busy_i,
  input  logic            mem_stall_req_i,
  input  logic            ex_valid_i,
  input  logic            ex_redirect_ena_i,
  input  logic [PC_W-1:0] ex_redirect_pc_i,
  input  logic            timer_intr_i,
  output logic [3:0]      stall_o,
  output logic [1:0]      flush_o,
  output logic            ex_stall_o,
  output logic            redirect_ena_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic            timer_intr_o,
  output logic            hang_o
);

  // state   | meaning
  // RUN     | normal flow; a redirect accepted here is the capture cycle
  // WAIT_IF | redirect pending, waiting for the fetch transaction to drain
  // ISSUE   | one cycle driving the registered redirect onto the PC
  typedef enum logic [1:0] {RUN, WAIT_IF, ISSUE} state_e;

  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX_C = WAIT_CNT_W'(WAIT_MAX);
  localparam logic [WAIT_CNT_W-1:0] WAIT_SAT_C = '1;

  state_e                state_q, state_d;
  logic [PC_W-1:0]       pending_pc_q, pending_pc_d;
  logic [PC_W-1:0]       redirect_pc_q, redirect_pc_d;
  logic                  redirect_ena_q, redirect_ena_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  hang_q, hang_d;
  logic                  intr_arm_q, intr_arm_d;
  logic [3:0]            stall_c;
  logic [1:0]            flush_c;

  always_comb begin
    state_d       = state_q;
    pending_pc_d  = pending_pc_q;
    redirect_pc_d = redirect_pc_q;
    wait_cnt_d    = '0;
    hang_d        = hang_q;
    intr_arm_d    = timer_intr_i;
    stall_c       = 4'b0000;
    flush_c       = 2'b00;

    case (state_q)
      RUN: begin
        if (ex_redirect_ena_i && !mem_stall_req_i) begin
          pending_pc_d = ex_redirect_pc_i;
          stall_c      = 4'b0001;
          flush_c      = 2'b11;
          if (if_busy_i) begin
            state_d = WAIT_IF;
          end else begin
            state_d       = ISSUE;
            redirect_pc_d = ex_redirect_pc_i;
          end
        end else if (if_busy_i) begin
          stall_c = 4'b0001;
          flush_c = 2'b01;
        end
      end
      WAIT_IF: begin
        stall_c = 4'b0001;
        flush_c = 2'b11;
        if (if_busy_i) begin
          wait_cnt_d = (wait_cnt_q == WAIT_SAT_C) ? wait_cnt_q : wait_cnt_q + 1'b1;
          if (wait_cnt_d >= WAIT_MAX_C) hang_d = 1'b1;
        end else begin
          state_d       = ISSUE;
          redirect_pc_d = pending_pc_q;
        end
      end
      ISSUE: begin
        flush_c = 2'b11;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    // A frozen pipe must keep every stage intact, so the LSU stall wins outright.
    if (mem_stall_req_i) begin
      stall_c = 4'b1111;
      flush_c = 2'b00;
    end

    redirect_ena_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      pending_pc_q   <= '0;
      redirect_pc_q  <= '0;
      redirect_ena_q <= 1'b0;
      wait_cnt_q     <= '0;
      hang_q         <= 1'b0;
      intr_arm_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_pc_q   <= pending_pc_d;
      redirect_pc_q  <= redirect_pc_d;
      redirect_ena_q <= redirect_ena_d;
      wait_cnt_q     <= wait_cnt_d;
      hang_q         <= hang_d;
      intr_arm_q     <= intr_arm_d;
    end
  end

  assign stall_o        = stall_c;
  assign flush_o        = flush_c;
  assign ex_stall_o     = stall_c[3];
  assign redirect_ena_o = redirect_ena_q;
  assign redirect_pc_o  = redirect_pc_q;
  assign hang_o         = hang_q;
  // Deliberately independent of ex_redirect_ena_i to avoid a loop through EX trap logic.
  assign timer_intr_o   = intr_arm_q & (state_q == RUN) & ~mem_stall_req_i & ex_valid_i;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: constant vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_pipe_ctrl;
  localparam int PC_W = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            if_busy_i, mem_stall_req_i, ex_valid_i, ex_redirect_ena_i, timer_intr_i;
  logic [PC_W-1:0] ex_redirect_pc_i;
  logic [3:0]      stall_o;
  logic [1:0]      flush_o;
  logic            ex_stall_o, redirect_ena_o, timer_intr_o, hang_o;
  logic [PC_W-1:0] redirect_pc_o;

  pipe_ctrl #(.PC_W(PC_W), .WAIT_CNT_W(8), .WAIT_MAX(200)) dut (
    .clk(clk), .rst(rst),
    .if_busy_i(if_busy_i), .mem_stall_req_i(mem_stall_req_i), .ex_valid_i(ex_valid_i),
    .ex_redirect_ena_i(ex_redirect_ena_i), .ex_redirect_pc_i(ex_redirect_pc_i),
    .timer_intr_i(timer_intr_i),
    .stall_o(stall_o), .flush_o(flush_o), .ex_stall_o(ex_stall_o),
    .redirect_ena_o(redirect_ena_o), .redirect_pc_o(redirect_pc_o),
    .timer_intr_o(timer_intr_o), .hang_o(hang_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_redir  = 0;

  // Reference model: a redirect is either absent, waiting for fetch to drain,
  // or being issued this cycle.
  bit              m_drain, m_issue, m_hang, m_arm;
  logic [PC_W-1:0] m_pc, m_out_pc;
  int              m_wait;

  typedef struct {
    logic       busy;
    logic       mem;
    logic       redir;
    logic [3:0] stall;
    logic [1:0] flush;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic busy, input logic mem, input logic valid,
                        input logic redir, input logic [PC_W-1:0] pc, input logic tim);
    if_busy_i         = busy;
    mem_stall_req_i   = mem;
    ex_valid_i        = valid;
    ex_redirect_ena_i = redir;
    ex_redirect_pc_i  = pc;
    timer_intr_i      = tim;
  endtask

  task automatic model_reset();
    m_drain = 0; m_issue = 0; m_hang = 0; m_arm = 0;
    m_pc = '0; m_out_pc = '0; m_wait = 0;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, '0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  // One clock: compare all outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit in_run, cap, n_drain, n_issue, n_hang;
    logic [3:0] e_stall;
    logic [1:0] e_flush;
    logic [PC_W-1:0] n_pc, n_out;
    int n_wait;
    @(negedge clk);
    in_run = !m_drain && !m_issue;
    cap    = in_run && ex_redirect_ena_i && !mem_stall_req_i;
    if (mem_stall_req_i)         e_stall = 4'b1111;
    else if (m_drain || cap)     e_stall = 4'b0001;
    else if (in_run && if_busy_i) e_stall = 4'b0001;
    else                         e_stall = 4'b0000;
    if (mem_stall_req_i)                  e_flush = 2'b00;
    else if (m_drain || m_issue || cap)   e_flush = 2'b11;
    else if (in_run && if_busy_i)         e_flush = 2'b01;
    else                                  e_flush = 2'b00;
    chk("stall", stall_o, e_stall);
    chk("flush", flush_o, e_flush);
    chk("ex_stall", ex_stall_o, e_stall[3]);
    chk("redirect_ena", redirect_ena_o, m_issue);
    chk("redirect_pc", redirect_pc_o, m_out_pc);
    chk("timer_intr", timer_intr_o, m_arm && in_run && !mem_stall_req_i && ex_valid_i);
    chk("hang", hang_o, m_hang);
    if (redirect_ena_o === 1'b1) n_redir++;

    n_drain = m_drain; n_issue = 0; n_hang = m_hang;
    n_pc = m_pc; n_out = m_out_pc; n_wait = m_wait;
    if (cap) begin
      n_pc = ex_redirect_pc_i;
      if (if_busy_i) begin n_drain = 1; n_wait = 0; end
      else begin n_issue = 1; n_out = ex_redirect_pc_i; end
    end
    if (m_drain) begin
      if (if_busy_i) begin
        n_wait = (m_wait < 255) ? m_wait + 1 : 255;
        if (n_wait >= 200) n_hang = 1;
      end else begin
        n_drain = 0; n_issue = 1; n_out = m_pc; n_wait = 0;
      end
    end
    @(posedge clk);
    m_arm = timer_intr_i;
    m_drain = n_drain; m_issue = n_issue; m_hang = n_hang;
    m_pc = n_pc; m_out_pc = n_out; m_wait = n_wait;
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 4'b0000, 2'b00};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 4'b0001, 2'b01};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 4'b1111, 2'b00};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 4'b1111, 2'b00};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 4'b0001, 2'b11};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 4'b0001, 2'b11};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 4'b1111, 2'b00};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 4'b1111, 2'b00};

    set_in(0, 0, 0, 0, '0, 0);
    #3;
    chk("rst_stall", stall_o, 4'b0000);
    chk("rst_flush", flush_o, 2'b00);
    chk("rst_redirect_ena", redirect_ena_o, 1'b0);
    chk("rst_redirect_pc", redirect_pc_o, '0);
    chk("rst_hang", hang_o, 1'b0);

    // Single-cycle RUN decode from a clean reset.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      set_in(tbl[i].busy, tbl[i].mem, 1'b0, tbl[i].redir, 64'h1234, 1'b0);
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), stall_o, tbl[i].stall);
      chk($sformatf("tbl%0d_flush", i), flush_o, tbl[i].flush);
      chk($sformatf("tbl%0d_ex_stall", i), ex_stall_o, tbl[i].stall[3]);
    end

    // Redirect with fetch idle.
    do_reset();
    set_in(0, 0, 1, 1, 64'h8000_0100, 0);
    tick();
    chk("t1_ena", redirect_ena_o, 1'b1);
    chk("t1_pc", redirect_pc_o, 64'h8000_0100);
    set_in(0, 0, 1, 0, '0, 0);
    tick();
    tick();

    // Redirect with fetch busy for five WAIT_IF cycles.
    n_redir = 0;
    set_in(1, 0, 1, 1, 64'h8000_0200, 0);
    tick();
    set_in(1, 0, 1, 0, '0, 0);
    repeat (4) tick();
    chk("t2_no_early_ena", redirect_ena_o, 1'b0);
    set_in(0, 0, 1, 0, '0, 0);
    tick();
    chk("t2_pc", redirect_pc_o, 64'h8000_0200);
    repeat (3) tick();
    chk("t2_one_pulse", n_redir, 1);

    // Memory stall holds off capture until it drops.
    set_in(0, 1, 1, 1, 64'h8000_0300, 0);
    repeat (3) tick();
    chk("t3_no_capture", redirect_ena_o, 1'b0);
    set_in(0, 0, 1, 1, 64'h8000_0300, 0);
    tick();
    chk("t3_pc", redirect_pc_o, 64'h8000_0300);
    set_in(0, 0, 1, 0, '0, 0);
    repeat (2) tick();

    // Timer interrupt raised during WAIT_IF is held until back in RUN.
    set_in(1, 0, 1, 1, 64'h8000_0400, 0);
    tick();
    set_in(1, 0, 1, 0, '0, 1);
    repeat (3) tick();
    set_in(0, 0, 1, 0, '0, 1);
    tick();
    tick();
    chk("t4_intr_first_run", timer_intr_o, 1'b1);
    tick();
    set_in(0, 0, 0, 0, '0, 0);
    tick();

    // Async reset in the middle of WAIT_IF discards the redirect.
    set_in(1, 0, 1, 1, 64'h8000_0500, 0);
    tick();
    set_in(1, 0, 1, 0, '0, 0);
    repeat (2) tick();
    set_in(0, 0, 0, 0, '0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_stall", stall_o, 4'b0000);
    chk("t6_flush", flush_o, 2'b00);
    chk("t6_redirect_ena", redirect_ena_o, 1'b0);
    chk("t6_redirect_pc", redirect_pc_o, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    n_redir = 0;
    repeat (4) tick();
    chk("t6_no_redirect", n_redir, 0);

    // Watchdog: 200 stuck WAIT_IF cycles set hang_o, which then sticks.
    set_in(1, 0, 1, 1, 64'h8000_0600, 0);
    tick();
    set_in(1, 0, 1, 0, '0, 0);
    repeat (199) tick();
    chk("t5_hang_before", hang_o, 1'b0);
    tick();
    chk("t5_hang_set", hang_o, 1'b1);
    set_in(0, 0, 1, 0, '0, 0);
    repeat (5) tick();
    chk("t5_hang_sticky", hang_o, 1'b1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
             $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
             {$urandom, $urandom}, $urandom_range(0, 1) == 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
